// File: rtl/ascon_dec_sched.sv
// ascon_dec_sched: two-requester round-robin scheduler that time-shares one
// byte-serial Ascon decryption wrapper (grant, load window, start, drain).
// Optional feature macro: ASCON_SCHED_TIMEOUT_EN adds a RUN-state watchdog
// that aborts the job if core_ready does not arrive within TIMEOUT cycles.
module ascon_dec_sched #(
    parameter int AD_BYTES  = 10,
    parameter int CT_BYTES  = 10,
    parameter int KEY_BYTES = 16,
    parameter int TAG_BYTES = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       load_en,
    output logic       core_rst,
    output logic       core_start,
    input  logic       core_ready,
    output logic       out_valid,
    output logic       out_last,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       busy
);

    localparam int MAX_KEY    = (KEY_BYTES > 16) ? KEY_BYTES : 16;
    localparam int MAX_DATA   = (AD_BYTES > CT_BYTES) ? AD_BYTES : CT_BYTES;
    localparam int LOAD_BEATS = ((MAX_KEY > MAX_DATA) ? MAX_KEY : MAX_DATA) + 1;
    localparam int OUT_BEATS  = (CT_BYTES > TAG_BYTES) ? CT_BYTES : TAG_BYTES;
    localparam int MAX_BEATS  = (LOAD_BEATS > OUT_BEATS) ? LOAD_BEATS : OUT_BEATS;
    localparam int CNT_W      = $clog2(MAX_BEATS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pick;
    logic             inJob;
    logic             reqLost;
    logic             runTimeout;

`ifdef ASCON_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Watchdog counts RUN cycles; it restarts from zero on every RUN entry
    always_comb begin
        tmr_d = '0;
        if (state_q == S_RUN) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    // Watchdog register
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign runTimeout = (state_q == S_RUN) && !core_ready &&
                        (tmr_q == TMR_W'(TIMEOUT - 1));
`else
    assign runTimeout = 1'b0;
`endif

    // The pointer names the preferred requester; fall back to the other one
    assign pick = ptr_q ? (req[1] ? 2'b10 : 2'b01)
                        : (req[0] ? 2'b01 : 2'b10);

    assign inJob   = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign reqLost = inJob && ((req & gnt_q) == 2'b00);

    // Next-state logic: job sequencing, with abort overriding everything
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_d   = pick;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q == CNT_W'(LOAD_BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (core_ready) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(OUT_BEATS - 1)) begin
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    ptr_d   = gnt_q[0];
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
        if (reqLost || runTimeout) begin
            done_d  = 2'b00;
            err_d   = gnt_q;
            gnt_d   = 2'b00;
            ptr_d   = gnt_q[0];
            cnt_d   = '0;
            state_d = S_IDLE;
        end
    end

    // State registers with synchronous reset favouring requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign load_en    = (state_q == S_LOAD);
    assign core_rst   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign core_start = (state_q == S_RUN);
    assign out_valid  = (state_q == S_DRAIN);
    assign out_last   = (state_q == S_DRAIN) && (cnt_q == CNT_W'(OUT_BEATS - 1));
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ascon_dec_sched.sv
// tb_ascon_dec_sched: table-driven job vectors plus hand-written abort,
// reset and timeout sequences; done/err pulses are matched against a queue.
// Honours ASCON_SCHED_TIMEOUT_EN (uses TIMEOUT=32 when defined).
module tb_ascon_dec_sched;

`ifdef ASCON_SCHED_TIMEOUT_EN
    localparam int TB_TIMEOUT = 32;
`else
    localparam int TB_TIMEOUT = 4096;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       load_en;
    logic       core_rst;
    logic       core_start;
    logic       core_ready;
    logic       out_valid;
    logic       out_last;
    logic [1:0] done;
    logic [1:0] err;
    logic       busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int id;
        bit isDone;
    } expEvt_t;

    typedef struct {
        logic [1:0] reqVal;
        logic [1:0] expGnt;
        int         expWait;
        int         readyDelay;
        bit         earlyReady;
    } jobVec_t;

    expEvt_t sb[$];
    expEvt_t ev;
    jobVec_t vecs[9];

    ascon_dec_sched #(
        .AD_BYTES (10),
        .CT_BYTES (10),
        .KEY_BYTES(16),
        .TAG_BYTES(16),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .load_en   (load_en),
        .core_rst  (core_rst),
        .core_start(core_start),
        .core_ready(core_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Invariants every cycle, and done/err pulses popped from the scoreboard
    always @(negedge clk) begin
        tests++;
        if ($countones(gnt) > 1 || (done != 2'b00 && err != 2'b00)) begin
            fails++;
            $display("[TB] FAIL invariant gnt=%b done=%b err=%b", gnt, done, err);
        end
        if (done != 2'b00 || err != 2'b00) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpectedPulse done=%b err=%b, required none", done, err);
            end else begin
                ev = sb.pop_front();
                if (ev.isDone ? (done !== (2'b01 << ev.id) || err !== 2'b00)
                              : (err !== (2'b01 << ev.id) || done !== 2'b00)) begin
                    fails++;
                    $display("[TB] FAIL pulse done=%b err=%b, required requester %0d %s",
                             done, err, ev.id, ev.isDone ? "done" : "err");
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 0);
        checkOutput({tag, "_coreRst"}, 32'(core_rst), 1);
        checkOutput({tag, "_coreStart"}, 32'(core_start), 0);
        checkOutput({tag, "_loadEn"}, 32'(load_en), 0);
        checkOutput({tag, "_outValid"}, 32'(out_valid), 0);
        checkOutput({tag, "_outLast"}, 32'(out_last), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_err"}, 32'(err), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic applyStimulus(input logic [1:0] reqVal);
        req = reqVal;
    endtask

    task automatic doReset();
        rst        = 1'b1;
        req        = 2'b00;
        core_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
    endtask

    // Wait for a grant, counting negedges and checking the core_rst gap
    task automatic waitGrant(input string tag, input logic [1:0] expGnt, input int expWait);
        int  waits = 0;
        bit  gapOk = 1'b1;
        while (gnt == 2'b00 && waits < 6) begin
            @(negedge clk);
            waits++;
            if (gnt == 2'b00 && core_rst !== 1'b1) gapOk = 1'b0;
        end
        checkOutput({tag, "_grantWait"}, 32'(waits), 32'(expWait));
        checkOutput({tag, "_grant"}, 32'(gnt), 32'(expGnt));
        checkOutput({tag, "_rstGap"}, 32'(gapOk), 1);
    endtask

    // Count load_en beats, optionally waving core_ready during beats 3..10
    task automatic countLoad(input string tag, input bit earlyReady);
        int beats = 0;
        while (load_en && beats < 40) begin
            core_ready = earlyReady && beats >= 3 && beats <= 10;
            beats++;
            @(negedge clk);
        end
        core_ready = 1'b0;
        checkOutput({tag, "_loadBeats"}, 32'(beats), 17);
    endtask

    task automatic countDrain(input string tag);
        int beats  = 0;
        bit lastOk = 1'b1;
        while (out_valid && beats < 40) begin
            beats++;
            if (out_last !== (beats == 16)) lastOk = 1'b0;
            @(negedge clk);
        end
        checkOutput({tag, "_drainBeats"}, 32'(beats), 16);
        checkOutput({tag, "_outLast"}, 32'(lastOk), 1);
    endtask

    task automatic runJob(input string tag, input jobVec_t v);
        bit runOk = 1'b1;
        applyStimulus(v.reqVal);
        sb.push_back('{id: (v.expGnt == 2'b10) ? 1 : 0, isDone: 1'b1});
        waitGrant(tag, v.expGnt, v.expWait);
        countLoad(tag, v.earlyReady);
        checkOutput({tag, "_coreStart"}, 32'(core_start), 1);
        for (int i = 0; i < v.readyDelay; i++) begin
            if (core_start !== 1'b1 || out_valid !== 1'b0) runOk = 1'b0;
            @(negedge clk);
        end
        checkOutput({tag, "_runHold"}, 32'(runOk), 1);
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        countDrain(tag);
        checkOutput({tag, "_doneGnt"}, 32'(gnt), 0);
        checkOutput({tag, "_doneCoreRst"}, 32'(core_rst), 1);
    endtask

    initial begin
        // Job table: pointer starts at 0 and moves to the other requester after each job
        vecs[0] = '{2'b01, 2'b01, 1, 3, 1'b0};
        vecs[1] = '{2'b01, 2'b01, 2, 0, 1'b0};
        vecs[2] = '{2'b10, 2'b10, 2, 5, 1'b0};
        vecs[3] = '{2'b11, 2'b01, 2, 1, 1'b0};
        vecs[4] = '{2'b11, 2'b10, 2, 2, 1'b0};
        vecs[5] = '{2'b11, 2'b01, 2, 0, 1'b0};
        vecs[6] = '{2'b11, 2'b10, 2, 4, 1'b0};
        vecs[7] = '{2'b10, 2'b10, 2, 0, 1'b0};
        vecs[8] = '{2'b01, 2'b01, 2, 6, 1'b1};

        doReset();
        for (int i = 0; i < 9; i++) begin
            runJob($sformatf("job%0d", i), vecs[i]);
        end

        // Abort: drop req[0] at load beat 5, then pending requester 1 is served
        doReset();
        applyStimulus(2'b11);
        sb.push_back('{id: 0, isDone: 1'b0});
        @(negedge clk);
        checkOutput("abort_grant", 32'(gnt), 1);
        for (int b = 0; b < 5; b++) @(negedge clk);
        checkOutput("abort_loadEn", 32'(load_en), 1);
        applyStimulus(2'b10);
        @(negedge clk);
        checkOutput("abort_err", 32'(err), 1);
        checkOutput("abort_gnt", 32'(gnt), 0);
        checkOutput("abort_coreRst", 32'(core_rst), 1);
        checkOutput("abort_loadEn2", 32'(load_en), 0);
        runJob("afterAbort", '{2'b10, 2'b10, 1, 2, 1'b0});
        runJob("ptrTo1", '{2'b01, 2'b01, 2, 0, 1'b0});

        // Reset mid-drain of a requester-1 job: pointer must return to 0
        applyStimulus(2'b10);
        waitGrant("rstJob", 2'b10, 2);
        countLoad("rstJob", 1'b0);
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstJob_inDrain", 32'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("midDrainReset");
        rst = 1'b0;
        runJob("ptrReset", '{2'b11, 2'b01, 1, 0, 1'b0});

        // RUN without core_ready: watchdog abort or indefinite wait
        applyStimulus(2'b01);
        waitGrant("stall", 2'b01, 2);
        countLoad("stall", 1'b0);
`ifdef ASCON_SCHED_TIMEOUT_EN
        begin
            int k = 0;
            sb.push_back('{id: 0, isDone: 1'b0});
            while (err == 2'b00 && k < 100) begin
                @(negedge clk);
                k++;
            end
            checkOutput("timeoutCycles", 32'(k), 32);
            checkOutput("timeoutGnt", 32'(gnt), 0);
        end
`else
        begin
            bit stillRun = 1'b1;
            for (int k = 0; k < 5000; k++) begin
                if (core_start !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || err !== 2'b00)
                    stillRun = 1'b0;
                @(negedge clk);
            end
            checkOutput("noTimeoutStillRun", 32'(stillRun), 1);
            sb.push_back('{id: 0, isDone: 1'b1});
            core_ready = 1'b1;
            @(negedge clk);
            core_ready = 1'b0;
            countDrain("stall");
        end
`endif

        applyStimulus(2'b00);
        for (int k = 0; k < 4; k++) @(negedge clk);
        checkOutput("scoreboardEmpty", 32'(sb.size()), 0);
        checkOutput("finalIdle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
